// File: rtl/fwdu_if.sv
// Signal bundle between the forwarding unit and the surrounding datapath.
// The slave modport is the forwarding unit; the master modport is the datapath side.
interface fwdu_if #(
    parameter int CW = 16
);
    logic          piprcon;
    logic          flush;
    logic [4:0]    id_rd;
    logic          id_regw;
    logic [1:0]    id_memr;
    logic [4:0]    idex_rs1;
    logic [4:0]    idex_rs2;
    logic [4:0]    idex_rd;
    logic [1:0]    idex_memr;
    logic [1:0]    fwda;
    logic [1:0]    fwdb;
    logic          fwd_err;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] fwd_cnt;

    modport master (
        output piprcon, flush, id_rd, id_regw, id_memr, idex_rs1, idex_rs2,
        input  idex_rd, idex_memr, fwda, fwdb, fwd_err, stall_cnt, fwd_cnt
    );

    modport slave (
        input  piprcon, flush, id_rd, id_regw, id_memr, idex_rs1, idex_rs2,
        output idex_rd, idex_memr, fwda, fwdb, fwd_err, stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/fwdu.sv
// Operand forwarding unit: shadows rd/regw/memr through ID/EX, EX/MEM, MEM/WB,
// drives ALU forward selects and keeps saturating stall/forward counters.
module fwdu #(
    parameter int CW = 16
) (
    input  logic  clk_i,
    input  logic  rstn_i,
    fwdu_if.slave bus
);
    typedef struct packed {
        logic [4:0] rd;
        logic       regw;
        logic [1:0] memr;
    } slot_t;

    slot_t         exs_q, exs_d;
    slot_t         mems_q, mems_d;
    slot_t         wbs_q, wbs_d;
    logic          err_q, err_d;
    logic [CW-1:0] stall_q, stall_d;
    logic [CW-1:0] fwdc_q, fwdc_d;
    logic [1:0]    fwda, fwdb;
    logic          load_hit;

    function automatic logic [1:0] fwd_sel(slot_t mem_s, slot_t wb_s, logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        // EX/MEM is the younger producer, so it wins over MEM/WB.
        if (mem_s.regw && (mem_s.rd != 5'd0) && (mem_s.rd == rs)) begin
            sel = 2'b10;
        end else if (wb_s.regw && (wb_s.rd != 5'd0) && (wb_s.rd == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        fwda     = fwd_sel(mems_q, wbs_q, bus.idex_rs1);
        fwdb     = fwd_sel(mems_q, wbs_q, bus.idex_rs2);
        load_hit = (mems_q.memr != 2'b00) && mems_q.regw && (mems_q.rd != 5'd0) &&
                   ((mems_q.rd == bus.idex_rs1) || (mems_q.rd == bus.idex_rs2));
    end

    always_comb begin
        wbs_d   = mems_q;
        mems_d  = bus.flush ? slot_t'('0) : exs_q;
        exs_d   = (bus.flush || bus.piprcon) ? slot_t'('0)
                                             : slot_t'{bus.id_rd, bus.id_regw, bus.id_memr};
        err_d   = err_q | load_hit;
        stall_d = stall_q;
        fwdc_d  = fwdc_q;
        // flush takes priority over a bubble request, so it does not count as a stall.
        if (bus.piprcon && !bus.flush && (stall_q != {CW{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
        if (((fwda != 2'b00) || (fwdb != 2'b00)) && (fwdc_q != {CW{1'b1}})) begin
            fwdc_d = fwdc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            exs_q   <= '0;
            mems_q  <= '0;
            wbs_q   <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            fwdc_q  <= '0;
        end else begin
            exs_q   <= exs_d;
            mems_q  <= mems_d;
            wbs_q   <= wbs_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            fwdc_q  <= fwdc_d;
        end
    end

    assign bus.idex_rd   = exs_q.rd;
    assign bus.idex_memr = exs_q.memr;
    assign bus.fwda      = fwda;
    assign bus.fwdb      = fwdb;
    assign bus.fwd_err   = err_q;
    assign bus.stall_cnt = stall_q;
    assign bus.fwd_cnt   = fwdc_q;
endmodule
